// File: rtl/skolem_chk_pkg.sv
// Shared definitions for the Skolem sweep checker.
//   SK_W      operand width of s, t, x
//   SK_IDX_W  sweep index width (one bit per s and t operand bit)
//   state_e   sweep controller states
//   idx_to_s / idx_to_t  split a sweep index into its s (low) and t (high) fields
package skolem_chk_pkg;

    localparam int unsigned SK_W     = 4;
    localparam int unsigned SK_IDX_W = 2 * SK_W;

    typedef enum logic [1:0] {
        StIdle,
        StSweep,
        StDrain,
        StDone
    } state_e;

    function automatic logic [SK_W-1:0] idx_to_s(input logic [SK_IDX_W-1:0] idx);
        return idx[SK_W-1:0];
    endfunction

    function automatic logic [SK_W-1:0] idx_to_t(input logic [SK_IDX_W-1:0] idx);
        return idx[SK_IDX_W-1:SK_W];
    endfunction

endpackage

// File: rtl/skolem_bvuge_add_check.sv
// Registered checker for bvuge(bvadd(x, s), t).
// Capture stage registers the {s,t,x} triple; the check stage evaluates it in the
// following cycle.
//   clk_i, rst_i          clock, asynchronous active-high reset
//   s_i, t_i, x_i         operands from the Skolem block interface
//   valid_i               triple is a live sweep vector
//   valid_o               captured triple is valid this cycle
//   fail_o                captured triple violates the formula (qualify with valid_o)
//   s_o, t_o, x_o         captured triple, for counterexample reporting
module skolem_bvuge_add_check #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] s_i,
    input  logic [W-1:0] t_i,
    input  logic [W-1:0] x_i,
    input  logic         valid_i,
    output logic         valid_o,
    output logic         fail_o,
    output logic [W-1:0] s_o,
    output logic [W-1:0] t_o,
    output logic [W-1:0] x_o
);

    logic [W-1:0] s_q, t_q, x_q;
    logic         valid_q;
    logic [W-1:0] sum;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            s_q     <= '0;
            t_q     <= '0;
            x_q     <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                s_q <= s_i;
                t_q <= t_i;
                x_q <= x_i;
            end
        end
    end

    // Sum is W bits wide on purpose: the carry out of bvadd is discarded.
    always_comb begin
        sum    = x_q + s_q;
        fail_o = (sum < t_q);
    end

    assign valid_o = valid_q;
    assign s_o     = s_q;
    assign t_o     = t_q;
    assign x_o     = x_q;

endmodule

// File: rtl/skolem_sweep_checker.sv
// Exhaustive sweep checker for a combinational 4-bit Skolem block
// (find_inv_bvuge_bvadd): drives every (s,t) pair, checks bvuge(bvadd(x,s),t).
//   clk, rst            clock, asynchronous active-high reset
//   start               begin a sweep (sampled only when idle; wins over abort)
//   abort               cancel a sweep in progress
//   sk_s, sk_t          registered operands to the Skolem block
//   sk_x                combinational result from the Skolem block
//   busy                sweep, drain or done cycle in progress
//   done                one-cycle pulse when the verdict is final
//   pass                last completed sweep had no failures
//   fail_count          number of failing vectors
//   ff_s, ff_t, ff_x    first failing vector of the current/last sweep
module skolem_sweep_checker
    import skolem_chk_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [SK_W-1:0]   sk_s,
    output logic [SK_W-1:0]   sk_t,
    input  logic [SK_W-1:0]   sk_x,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [SK_IDX_W:0] fail_count,
    output logic [SK_W-1:0]   ff_s,
    output logic [SK_W-1:0]   ff_t,
    output logic [SK_W-1:0]   ff_x
);

    localparam int unsigned       W         = SK_W;
    localparam int unsigned       IDX_W     = SK_IDX_W;
    localparam logic [IDX_W-1:0]  IDX_LAST  = '1;
    localparam logic [IDX_W:0]    FAIL_MAX  = {1'b1, {IDX_W{1'b0}}};

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   fail_count_q, fail_count_d;
    logic [W-1:0]     ff_s_q, ff_s_d, ff_t_q, ff_t_d, ff_x_q, ff_x_d;
    logic             pass_q, pass_d;

    logic             start_sweep;
    logic             drive_vec;
    logic             count_en;
    logic             chk_valid, chk_fail;
    logic [W-1:0]     chk_s, chk_t, chk_x;

    assign start_sweep = (state_q == StIdle) && start;
    // A vector counts only if it was not cancelled by abort in its own cycle.
    assign drive_vec   = (state_q == StSweep) && !abort;

    skolem_bvuge_add_check #(
        .W (W)
    ) u_check (
        .clk_i   (clk),
        .rst_i   (rst),
        .s_i     (sk_s),
        .t_i     (sk_t),
        .x_i     (sk_x),
        .valid_i (drive_vec),
        .valid_o (chk_valid),
        .fail_o  (chk_fail),
        .s_o     (chk_s),
        .t_o     (chk_t),
        .x_o     (chk_x)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. One drain cycle lets the last captured vector be checked,
    // so the verdict is complete in the done cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StSweep;
            StSweep: begin
                if (abort)                 state_d = StIdle;
                else if (idx_q == IDX_LAST) state_d = StDrain;
            end
            StDrain: state_d = abort ? StIdle : StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

    // Datapath next-state
    always_comb begin
        idx_d        = idx_q;
        fail_count_d = fail_count_q;
        ff_s_d       = ff_s_q;
        ff_t_d       = ff_t_q;
        ff_x_d       = ff_x_q;
        pass_d       = pass_q;
        count_en     = chk_valid && chk_fail && (state_q != StIdle);

        if (start_sweep) begin
            idx_d        = '0;
            fail_count_d = '0;
            ff_s_d       = '0;
            ff_t_d       = '0;
            ff_x_d       = '0;
            pass_d       = 1'b0;
        end else begin
            // Index stops at the last vector so vector 0 is never re-issued.
            if (drive_vec && (idx_q != IDX_LAST)) begin
                idx_d = idx_q + 1'b1;
            end
            if (count_en) begin
                if (fail_count_q != FAIL_MAX) begin
                    fail_count_d = fail_count_q + 1'b1;
                end
                if (fail_count_q == '0) begin
                    ff_s_d = chk_s;
                    ff_t_d = chk_t;
                    ff_x_d = chk_x;
                end
            end
            // Loaded on entry to done so the verdict is visible with the pulse.
            if ((state_q == StDrain) && (state_d == StDone)) begin
                pass_d = (fail_count_d == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            fail_count_q <= '0;
            ff_s_q       <= '0;
            ff_t_q       <= '0;
            ff_x_q       <= '0;
            pass_q       <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            fail_count_q <= fail_count_d;
            ff_s_q       <= ff_s_d;
            ff_t_q       <= ff_t_d;
            ff_x_q       <= ff_x_d;
            pass_q       <= pass_d;
        end
    end

    assign sk_s       = idx_to_s(idx_q);
    assign sk_t       = idx_to_t(idx_q);
    assign fail_count = fail_count_q;
    assign ff_s       = ff_s_q;
    assign ff_t       = ff_t_q;
    assign ff_x       = ff_x_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Self-checking bench for skolem_sweep_checker. A stand-in Skolem block selected
// by 'mode' feeds sk_x; expected verdicts come from an exhaustive arithmetic model.
module tb_skolem_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] sk_s, sk_t, sk_x;
    logic       busy, done, pass;
    logic [8:0] fail_count;
    logic [3:0] ff_s, ff_t, ff_x;

    int checks = 0;
    int failures = 0;
    int mode = 0;
    logic [3:0] rand_tab [256];

    // Observations from the most recent run_sweep
    int r_done_cyc, r_done_pulses, r_vec_err, r_busy_err, r_busy_after, r_hold_err;
    int r_cnt, r_pass, r_fs, r_ft, r_fx;
    // Model results
    int e_cnt, e_fs, e_ft, e_fx;

    always #5 clk = ~clk;

    skolem_sweep_checker dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .sk_s       (sk_s),
        .sk_t       (sk_t),
        .sk_x       (sk_x),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_count (fail_count),
        .ff_s       (ff_s),
        .ff_t       (ff_t),
        .ff_x       (ff_x)
    );

    // Stand-in Skolem blocks: 0 golden ~s, 1 zero, 2 t-s, 3 t-s-1, 4 random table
    always_comb begin
        case (mode)
            0:       sk_x = ~sk_s;
            1:       sk_x = 4'd0;
            2:       sk_x = sk_t - sk_s;
            3:       sk_x = sk_t - sk_s - 4'd1;
            default: sk_x = rand_tab[{sk_t, sk_s}];
        endcase
    end

    function automatic int model_x(input int s, input int t);
        case (mode)
            0:       return 15 - s;
            1:       return 0;
            2:       return (t - s + 16) % 16;
            3:       return (t - s + 15) % 16;
            default: return int'(rand_tab[t * 16 + s]);
        endcase
    endfunction

    // Expected count and first counterexample over vector indices 0..upto
    task automatic model_sweep(input int upto);
        int s, t, x;
        e_cnt = 0; e_fs = 0; e_ft = 0; e_fx = 0;
        for (int i = 0; i <= upto; i++) begin
            s = i % 16;
            t = i / 16;
            x = model_x(s, t);
            if (((x + s) % 16) < t) begin
                if (e_cnt == 0) begin
                    e_fs = s; e_ft = t; e_fx = x;
                end
                e_cnt++;
            end
        end
    endtask

    // Pulses start in cycle 0 and records observations up to the done pulse.
    task automatic run_sweep(input int stray);
        int k;
        r_done_cyc = -1; r_done_pulses = 0; r_vec_err = 0; r_busy_err = 0; r_hold_err = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (busy !== 1'b1) r_busy_err++;
            if (cyc <= 256) begin
                k = cyc - 1;
                if (sk_s !== k[3:0] || sk_t !== k[7:4]) r_vec_err++;
            end
            if (done === 1'b1) begin
                r_done_cyc = cyc;
                r_done_pulses++;
                break;
            end
            if (stray != 0 && (cyc % 50) == 7) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        r_cnt = int'(fail_count); r_pass = int'(pass);
        r_fs = int'(ff_s); r_ft = int'(ff_t); r_fx = int'(ff_x);
        @(negedge clk);
        r_busy_after = int'(busy);
        for (int j = 0; j < 6; j++) begin
            if (done === 1'b1) r_done_pulses++;
            if (sk_s !== 4'hf || sk_t !== 4'hf) r_hold_err++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, pass, fail_count, sk_s, sk_t, ff_s, ff_t, ff_x} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b pass=%b cnt=%0d s=%0d t=%0d ff=%0d/%0d/%0d expected all 0",
                     busy, done, pass, fail_count, sk_s, sk_t, ff_s, ff_t, ff_x);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_golden();
        mode = 0;
        model_sweep(255);
        run_sweep(0);
        checks++;
        if (r_done_cyc != 258) begin
            failures++; $display("FAIL golden_done_cycle: got %0d expected 258", r_done_cyc);
        end
        checks++;
        if (r_vec_err != 0) begin
            failures++; $display("FAIL golden_vector_order: got %0d bad cycles expected 0", r_vec_err);
        end
        checks++;
        if (r_busy_err != 0 || r_busy_after != 0) begin
            failures++;
            $display("FAIL golden_busy: got %0d low cycles, after=%0d expected 0,0", r_busy_err, r_busy_after);
        end
        checks++;
        if (r_pass != 1 || r_cnt != e_cnt) begin
            failures++;
            $display("FAIL golden_verdict: got pass=%0d cnt=%0d expected pass=1 cnt=%0d", r_pass, r_cnt, e_cnt);
        end
        checks++;
        if (r_done_pulses != 1 || r_hold_err != 0) begin
            failures++;
            $display("FAIL golden_after: got pulses=%0d hold_err=%0d expected 1,0", r_done_pulses, r_hold_err);
        end
    endtask

    // Shared body for the failing models: verdict vs. the arithmetic model
    task automatic test_model(input int m, input string name);
        mode = m;
        model_sweep(255);
        run_sweep(0);
        checks++;
        if (r_done_cyc != 258) begin
            failures++; $display("FAIL %s_done_cycle: got %0d expected 258", name, r_done_cyc);
        end
        checks++;
        if (r_cnt != e_cnt) begin
            failures++; $display("FAIL %s_count: got %0d expected %0d", name, r_cnt, e_cnt);
        end
        checks++;
        if (r_pass != ((e_cnt == 0) ? 1 : 0)) begin
            failures++; $display("FAIL %s_pass: got %0d expected %0d", name, r_pass, e_cnt == 0);
        end
        checks++;
        if (r_fs != e_fs || r_ft != e_ft || r_fx != e_fx) begin
            failures++;
            $display("FAIL %s_first: got s=%0d t=%0d x=%0d expected s=%0d t=%0d x=%0d",
                     name, r_fs, r_ft, r_fx, e_fs, e_ft, e_fx);
        end
    endtask

    task automatic test_fixed_models();
        test_model(1, "zero");
        checks++;
        if (r_cnt != 120 || r_fs != 0 || r_ft != 1 || r_fx != 0) begin
            failures++;
            $display("FAIL zero_known: got cnt=%0d ff=%0d/%0d/%0d expected 120 0/1/0", r_cnt, r_fs, r_ft, r_fx);
        end
        test_model(2, "exact");
        test_model(3, "off_by_one");
        checks++;
        if (r_cnt != 240) begin
            failures++; $display("FAIL off_by_one_known: got %0d expected 240", r_cnt);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 256; i++) rand_tab[i] = 4'($urandom_range(0, 15));
            test_model(4, "random");
        end
    endtask

    task automatic test_abort();
        int extra;
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc < 100; cyc++) @(posedge clk);
        @(negedge clk);                       // cycle 100
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);                       // cycle 101
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL abort_busy: got %b expected 0", busy);
        end
        // Vectors 0..98 were fully checked before the abort took effect.
        model_sweep(98);
        checks++;
        if (int'(fail_count) != e_cnt || pass !== 1'b0 || int'(ff_t) != e_ft || int'(ff_s) != e_fs) begin
            failures++;
            $display("FAIL abort_partial: got cnt=%0d pass=%b ff=%0d/%0d expected cnt=%0d pass=0 ff=%0d/%0d",
                     fail_count, pass, ff_s, ff_t, e_cnt, e_fs, e_ft);
        end
        extra = 0;
        for (int j = 0; j < 10; j++) begin
            if (done === 1'b1 || busy === 1'b1) extra++;
            @(negedge clk);
        end
        checks++;
        if (extra != 0) begin
            failures++; $display("FAIL abort_no_done: got %0d active cycles expected 0", extra);
        end
        // Abort while idle must be harmless.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        mode = 0;
        run_sweep(0);
        checks++;
        if (r_done_cyc != 258 || r_pass != 1 || r_cnt != 0 || r_vec_err != 0) begin
            failures++;
            $display("FAIL abort_restart: got done=%0d pass=%0d cnt=%0d vec_err=%0d expected 258,1,0,0",
                     r_done_cyc, r_pass, r_cnt, r_vec_err);
        end
    endtask

    task automatic test_async_reset();
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (60) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, pass, fail_count, sk_s, sk_t, ff_s, ff_t, ff_x} !== '0) begin
            failures++;
            $display("FAIL async_reset: got busy=%b cnt=%0d s=%0d t=%0d ff=%0d/%0d/%0d expected all 0",
                     busy, fail_count, sk_s, sk_t, ff_s, ff_t, ff_x);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mode = 0;
        run_sweep(1);
        checks++;
        if (r_done_cyc != 258 || r_done_pulses != 1 || r_pass != 1) begin
            failures++;
            $display("FAIL stray_start: got done=%0d pulses=%0d pass=%0d expected 258,1,1",
                     r_done_cyc, r_done_pulses, r_pass);
        end
    endtask

    task automatic test_back_to_back();
        test_model(3, "b2b_first");
        mode = 0;
        run_sweep(0);
        checks++;
        if (r_pass != 1 || r_cnt != 0 || r_fs != 0 || r_ft != 0 || r_fx != 0 || r_done_cyc != 258) begin
            failures++;
            $display("FAIL b2b_second: got pass=%0d cnt=%0d ff=%0d/%0d/%0d done=%0d expected 1,0,0/0/0,258",
                     r_pass, r_cnt, r_fs, r_ft, r_fx, r_done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_fixed_models();
        test_random();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
